// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB-first, one bit per bit_en tick.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  // state  | meaning
  // IDLE   | shifter empty; loads from hold as soon as hold is full
  // SHIFT  | presenting shreg MSB; advances on bit_en
  // PARITY | presenting even parity of the word just shifted (parity build only)
`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             accept;
  logic             last_bit;
  logic             load;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready comes straight from a flop, so accept and drain of hold are mutually exclusive.
  assign accept   = in_valid & ~hold_full_q;
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign in_ready = ~hold_full_q;
  assign busy     = (state_q != IDLE) | hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    load        = 1'b0;
    dout        = 1'b0;
    dout_valid  = 1'b0;
    word_done   = 1'b0;

    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        load = hold_full_q;
      end
      SHIFT: begin
        dout       = shreg_q[WIDTH-1];
        dout_valid = 1'b1;
        if (bit_en) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit) begin
            word_done = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        dout       = parity_q;
        dout_valid = 1'b1;
        if (bit_en) begin
          if (hold_full_q) load = 1'b1;
          else             state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Reloading directly from the last-bit edge keeps consecutive words gapless.
    if (load) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      state_d     = SHIFT;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: vector table, directed corner sequences and a randomized run against a bit-queue model.
module tb_serial_bit_feeder;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W  = 8;
  localparam int NB = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         bit_en = 1'b0;
  logic         dout, dout_valid, word_done, busy;

  logic [3:0]   in_data4 = 4'hB;
  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic         bit_en4 = 1'b0;
  logic         dout4, dout_valid4, word_done4, busy4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_en(bit_en), .dout(dout), .dout_valid(dout_valid), .word_done(word_done), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .bit_en(bit_en4), .dout(dout4), .dout_valid(dout_valid4), .word_done(word_done4), .busy(busy4)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a FIFO of the bits still owed on dout, tagged with "last data bit of word".
  typedef struct packed { logic b; logic last; } mbit_t;
  mbit_t mq[$];
  bit    gap_now = 1'b0;

  always @(negedge clk) begin
    bit    exp_valid;
    bit    was_empty;
    bit    acc;
    mbit_t e;
    #2;
    if (!rst) begin
      mq.delete();
      gap_now = 1'b0;
      chk("rst_dout_valid", 32'(dout_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
    end else begin
      exp_valid = (mq.size() > 0) && !gap_now;
      chk("m_dout_valid", 32'(dout_valid), 32'(exp_valid));
      chk("m_busy", 32'(busy), 32'(mq.size() > 0));
      chk("m_dout", 32'(dout), exp_valid ? 32'(mq[0].b) : 32'(0));
      chk("m_word_done", 32'(word_done), 32'(exp_valid && bit_en && mq[0].last));
      if (exp_valid && bit_en) void'(mq.pop_front());
      was_empty = (mq.size() == 0);
      acc = in_valid && in_ready;
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) begin
          e.b = in_data[i];
          e.last = (i == 0);
          mq.push_back(e);
        end
        if (PAR != 0) begin
          e.b = ^in_data;
          e.last = 1'b0;
          mq.push_back(e);
        end
      end
      // A word landing in an empty pipeline spends one cycle in hold before its MSB appears.
      gap_now = acc && was_empty;
    end
  end

  // Sends nw words (w0, then w1), paces bit_en at one tick per `period` valid cycles, and collects the stream.
  task automatic stream(input logic [7:0] w0, input logic [7:0] w1, input int nw, input int period,
                        output logic [31:0] bits, output int nvalid, output int ndone,
                        output int dgap, output bit rdy_low);
    int sent = 0;
    int c = 0;
    int vstart = -1;
    int last_done = -1;
    bit fin = 1'b0;
    bits = '0; nvalid = 0; ndone = 0; dgap = -1; rdy_low = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (sent < nw) begin
        in_valid = 1'b1;
        in_data  = (sent == 0) ? w0 : w1;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (dout_valid && vstart < 0) vstart = c;
      bit_en = dout_valid ? (((c - vstart) % period) == period - 1) : 1'b0;
      #1;
      if (in_valid && in_ready) sent++;
      if (in_valid && !in_ready) rdy_low = 1'b1;
      if (dout_valid) begin
        nvalid++;
        if (bit_en) bits = {bits[30:0], dout};
      end
      if (word_done) begin
        ndone++;
        if (last_done >= 0) dgap = c - last_done;
        last_done = c;
      end
      if (!dout_valid && vstart >= 0) fin = 1'b1;
      c++;
      if (c > 400) begin
        chk("stream_timeout", 32'(c), 32'(400));
        fin = 1'b1;
      end
    end
    in_valid = 1'b0;
    bit_en   = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    int          period;
    logic [31:0] exp_bits;
    int          exp_valid;
  } vec_t;

  vec_t        vt[6];
  logic [7:0]  vdata[6];
  int          vper[6];
  logic [31:0] bits;
  logic [15:0] bits4;
  int          nvalid, ndone, dgap, nv4, acc4;
  bit          rdy_low, st4;

  initial begin
    vdata = '{8'hB0, 8'hF0, 8'h07, 8'h01, 8'hFF, 8'h5A};
    vper  = '{1, 3, 1, 2, 1, 4};
    for (int i = 0; i < 6; i++) begin
      vt[i].data      = vdata[i];
      vt[i].period    = vper[i];
      vt[i].exp_bits  = (PAR != 0) ? {23'b0, vdata[i], ^vdata[i]} : {24'b0, vdata[i]};
      vt[i].exp_valid = vper[i] * NB;
    end

    #3;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_dout", 32'(dout), 32'(0));
    chk("reset_dout_valid", 32'(dout_valid), 32'(0));
    chk("reset_word_done", 32'(word_done), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      stream(vt[i].data, 8'h00, 1, vt[i].period, bits, nvalid, ndone, dgap, rdy_low);
      chk($sformatf("vec%0d_bits", i), bits, vt[i].exp_bits);
      chk($sformatf("vec%0d_valid_cycles", i), 32'(nvalid), 32'(vt[i].exp_valid));
      chk($sformatf("vec%0d_word_done", i), 32'(ndone), 32'(1));
    end

    // Back-to-back words with in_valid held: must stream without a gap.
    stream(8'hA5, 8'h3C, 2, 1, bits, nvalid, ndone, dgap, rdy_low);
    chk("b2b_bits", bits, (PAR != 0) ? {14'b0, 8'hA5, 1'b0, 8'h3C, 1'b0} : {16'b0, 8'hA5, 8'h3C});
    chk("b2b_valid_cycles", 32'(nvalid), 32'(2 * NB));
    chk("b2b_word_done", 32'(ndone), 32'(2));
    chk("b2b_done_spacing", 32'(dgap), 32'(NB));
    chk("b2b_ready_low", 32'(rdy_low), 32'(1));

    // Async reset in the middle of 8'hFF, then 8'h80 must start from its MSB.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; bit_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    chk("midword_valid", 32'(dout_valid), 32'(1));
    rst = 1'b0;
    #1;
    chk("async_dout", 32'(dout), 32'(0));
    chk("async_dout_valid", 32'(dout_valid), 32'(0));
    chk("async_in_ready", 32'(in_ready), 32'(1));
    chk("async_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bit_en = 1'b0;
    stream(8'h80, 8'h00, 1, 1, bits, nvalid, ndone, dgap, rdy_low);
    chk("restart_bits", bits, (PAR != 0) ? {23'b0, 8'h80, 1'b1} : 32'h80);
    chk("restart_valid_cycles", 32'(nvalid), 32'(NB));

    // WIDTH=4 instance: two 4'hB words gapless.
    bits4 = '0; nv4 = 0; acc4 = 0; st4 = 1'b0; bit_en4 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      in_valid4 = (acc4 < 2);
      #1;
      if (in_valid4 && in_ready4) acc4++;
      if (dout_valid4) begin
        nv4++;
        bits4 = {bits4[14:0], dout4};
        st4 = 1'b1;
      end else if (st4) begin
        break;
      end
    end
    in_valid4 = 1'b0;
    chk("w4_bits", 32'(bits4), (PAR != 0) ? 32'b1011_1_1011_1 : 32'b1011_1011);
    chk("w4_valid_cycles", 32'(nv4), 32'(2 * (4 + PAR)));

    // Randomized traffic; the always-block model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      bit_en   = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    bit_en   = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    chk("drain_busy", 32'(busy), 32'(0));
    chk("drain_model_empty", 32'(mq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
